// File: rtl/alarm_clock_multi_pkg.sv
// Shared time types and helpers for the multi-alarm clock.
// Times are hours/minutes pairs; all arithmetic wraps at 24 h.
package clock_pkg;

    localparam int HOURS_W = 6;
    localparam int MIN_W   = 7;

    typedef struct packed {
        logic [HOURS_W-1:0] hours;
        logic [MIN_W-1:0]   minutes;
    } clk_time_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } alarm_state_t;

    function automatic clk_time_t time_add_min(clk_time_t t, int m);
        clk_time_t r;
        int        mm;
        int        hh;
        mm = int'(t.minutes) + (m % 60);
        hh = int'(t.hours) + ((m / 60) % 24);
        if (mm >= 60) begin
            mm = mm - 60;
            hh = hh + 1;
        end
        if (hh >= 24) hh = hh - 24;
        r.hours   = HOURS_W'(hh);
        r.minutes = MIN_W'(mm);
        return r;
    endfunction

    function automatic logic time_valid(clk_time_t t);
        return (t.hours < HOURS_W'(24)) && (t.minutes < MIN_W'(60));
    endfunction

endpackage

// File: rtl/alarm_clock_multi_if.sv
// Control and status bundle of the multi-alarm clock.
// master drives set/alarm/ack/snooze, slave drives time and alarm status.
interface alarm_clock_multi_if #(
    parameter int NUM_ALARMS = 4
);
    import clock_pkg::*;

    localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

    logic               set_valid;
    logic [HOURS_W-1:0] set_hours;
    logic [MIN_W-1:0]   set_minutes;
    logic               alm_wr;
    logic [IDX_W-1:0]   alm_idx;
    logic               alm_en;
    logic [HOURS_W-1:0] alm_hours;
    logic [MIN_W-1:0]   alm_minutes;
    logic               ack;
    logic               snooze;
    logic [HOURS_W-1:0] hours;
    logic [MIN_W-1:0]   minutes;
    logic               minute_tick;
    logic               alarm_trigger;
    logic [IDX_W-1:0]   alarm_idx;

    modport master (
        output set_valid, set_hours, set_minutes,
        output alm_wr, alm_idx, alm_en, alm_hours, alm_minutes,
        output ack, snooze,
        input  hours, minutes, minute_tick, alarm_trigger, alarm_idx
    );

    modport slave (
        input  set_valid, set_hours, set_minutes,
        input  alm_wr, alm_idx, alm_en, alm_hours, alm_minutes,
        input  ack, snooze,
        output hours, minutes, minute_tick, alarm_trigger, alarm_idx
    );

endinterface

// File: rtl/alarm_clock_multi_channel.sv
// One alarm channel: enable, target time, ring/snooze FSM.
// Snooze state and target exist only when SNOOZE_EN is defined.
module alarm_channel
    import clock_pkg::*;
#(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_MIN   = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      wr,
    input  logic      wr_en,
    input  clk_time_t wr_time,
    input  clk_time_t now,
    input  logic      time_upd,
    input  logic      tick,
    input  logic      ack,
    input  logic      snooze,
    output logic      ringing
);

    localparam int RC_W = $clog2(RING_MIN + 1);

    logic             en;
    clk_time_t        alarm_t;
    alarm_state_t     state;
    logic [RC_W-1:0]  ring_cnt;
    logic             hit_alarm;
    logic             ring_done;

    // A match needs a fresh time value, so a held time never re-fires.
    assign hit_alarm = time_upd && (now == alarm_t);
    assign ring_done = tick && (ring_cnt == RC_W'(RING_MIN - 1));

`ifdef SNOOZE_EN
    clk_time_t snz_t;
    logic      hit_snz;
    assign hit_snz = time_upd && (now == snz_t);
`else
    logic unused_snooze;
    assign unused_snooze = snooze;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en       <= 1'b0;
            alarm_t  <= '0;
            state    <= IDLE;
            ring_cnt <= '0;
`ifdef SNOOZE_EN
            snz_t    <= '0;
`endif
        end else if (wr) begin
            en       <= wr_en;
            alarm_t  <= wr_time;
            state    <= IDLE;
            ring_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && hit_alarm) begin
                        state    <= RINGING;
                        ring_cnt <= '0;
                    end
                end
                RINGING: begin
                    if (ack) begin
                        state <= IDLE;
`ifdef SNOOZE_EN
                    end else if (snooze) begin
                        state <= SNOOZED;
                        snz_t <= time_add_min(now, SNOOZE_MIN);
`endif
                    end else if (ring_done) begin
                        state <= IDLE;
                    end else if (tick) begin
                        ring_cnt <= ring_cnt + 1'b1;
                    end
                end
`ifdef SNOOZE_EN
                SNOOZED: begin
                    // Match wins over a same-cycle ack.
                    if (hit_snz) begin
                        state    <= RINGING;
                        ring_cnt <= '0;
                    end else if (ack) begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign ringing = (state == RINGING);

endmodule

// File: rtl/alarm_clock_multi.sv
// 24 h clock with NUM_ALARMS independent alarm channels.
// Define SNOOZE_EN to build the snooze input and SNOOZED state.
module alarm_clock_multi
    import clock_pkg::*;
#(
    parameter int TICK_COUNT_MAX = 100000000,
    parameter int NUM_ALARMS     = 4,
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_MIN       = 1
) (
    input logic          clk,
    input logic          rst,
    alarm_clock_multi_if.slave bus
);

    localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam int CNT_W = (TICK_COUNT_MAX > 1) ? $clog2(TICK_COUNT_MAX) : 1;

    clk_time_t             now;
    clk_time_t             set_t;
    clk_time_t             alm_t;
    logic [CNT_W-1:0]      cnt;
    logic                  time_upd;
    logic                  set_ok;
    logic                  tc;
    logic                  tick;
    logic                  wr_ok;
    logic [NUM_ALARMS-1:0] ringing;
    logic [IDX_W-1:0]      idx;

    assign set_t  = {bus.set_hours, bus.set_minutes};
    assign alm_t  = {bus.alm_hours, bus.alm_minutes};
    assign set_ok = bus.set_valid && time_valid(set_t);
    assign tc     = (cnt == CNT_W'(TICK_COUNT_MAX - 1));
    // A valid set overrides the terminal count, so no tick is reported.
    assign tick   = tc && !set_ok && !rst;
    assign wr_ok  = bus.alm_wr && time_valid(alm_t)
                    && (int'(bus.alm_idx) < NUM_ALARMS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            now      <= '0;
            time_upd <= 1'b0;
        end else begin
            time_upd <= set_ok || tick;
            if (set_ok) begin
                cnt <= '0;
                now <= set_t;
            end else if (tc) begin
                cnt <= '0;
                now <= time_add_min(now, 1);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
        alarm_channel #(
            .SNOOZE_MIN (SNOOZE_MIN),
            .RING_MIN   (RING_MIN)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .wr       (wr_ok && (bus.alm_idx == IDX_W'(i))),
            .wr_en    (bus.alm_en),
            .wr_time  (alm_t),
            .now      (now),
            .time_upd (time_upd),
            .tick     (tick),
            .ack      (bus.ack),
            .snooze   (bus.snooze),
            .ringing  (ringing[i])
        );
    end

    always_comb begin
        idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (ringing[i]) idx = IDX_W'(i);
        end
    end

    assign bus.hours         = now.hours;
    assign bus.minutes       = now.minutes;
    assign bus.minute_tick   = tick;
    assign bus.alarm_trigger = |ringing;
    assign bus.alarm_idx     = idx;

endmodule
